// File: rtl/h1_delta.sv
// h1_delta: sigmoid backward-path gradient, delta = e * y * (1 - y), IEEE-754 single,
// one shared truncating multiplier. Define H1_DELTA_LR_EN to add a final scale by LR.
module h1_delta #(
    parameter logic [31:0] LR = 32'h3DCCCCCD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] act,
    input  logic [31:0] err,
    output logic        busy,
    output logic        done,
    output logic [31:0] delta
);

    localparam int unsigned W    = 32;
    localparam int unsigned MW   = 24;
    localparam int unsigned PW   = 2 * MW;
    localparam int unsigned EXPW = 10;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SUB  = 3'd1,
        S_MUL1 = 3'd2,
        S_MUL2 = 3'd3,
`ifdef H1_DELTA_LR_EN
        S_MUL3 = 3'd4,
`endif
        S_DONE = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    act_q, act_d;
    logic [W-1:0]    err_q, err_d;
    logic [W-1:0]    acc_q, acc_d;
    logic [W-1:0]    delta_q, delta_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;

    logic [W-1:0]    mul_a_c, mul_b_c, mul_res_c;
    logic [PW-1:0]   mul_prod_c;
    logic [EXPW-1:0] mul_exp_c;
    logic [22:0]     mul_frac_c;
    logic            mul_sign_c;

    logic [MW-1:0]   om_shift_c, om_diff_c;
    logic [4:0]      om_lz_c;
    logic [W-1:0]    om_res_c;
    logic            clamp_c;
    logic            accept_c;

    // Shared multiplier operand select; LR is the operand for the optional scale step
    always_comb begin
        mul_a_c = acc_q;
        mul_b_c = LR;
        case (state_q)
            S_MUL1: begin
                mul_a_c = act_q;
                mul_b_c = acc_q;
            end
            S_MUL2:  mul_b_c = err_q;
            default: ;
        endcase
    end

    // Truncating FP multiply; exponent kept biased by +127 to stay unsigned
    always_comb begin
        mul_sign_c = mul_a_c[31] ^ mul_b_c[31];
        mul_prod_c = PW'({1'b1, mul_a_c[22:0]}) * PW'({1'b1, mul_b_c[22:0]});
        mul_exp_c  = EXPW'(mul_a_c[30:23]) + EXPW'(mul_b_c[30:23]) + EXPW'(mul_prod_c[PW-1]);
        mul_frac_c = mul_prod_c[PW-1] ? 23'(mul_prod_c >> 24) : 23'(mul_prod_c >> 23);
        if ((mul_a_c[30:23] == 8'd0) || (mul_b_c[30:23] == 8'd0) || (mul_exp_c <= EXPW'(127))) begin
            mul_res_c = {mul_sign_c, 31'd0};
        end else if (mul_exp_c >= EXPW'(382)) begin
            mul_res_c = {mul_sign_c, 31'h7F7FFFFF};
        end else begin
            mul_res_c = {mul_sign_c, 8'(mul_exp_c - EXPW'(127)), mul_frac_c};
        end
    end

    // 1.0 - y by aligning y's mantissa to the 2^0 position, then renormalising
    always_comb begin
        om_shift_c = {1'b1, act_q[22:0]} >> (8'd127 - act_q[30:23]);
        om_diff_c  = 24'h800000 - om_shift_c;
        om_lz_c    = 5'd0;
        for (int i = 0; i < MW; i++) begin
            if (om_diff_c[i]) om_lz_c = 5'(23 - i);
        end
        if (act_q[30:23] >= 8'd127) begin
            om_res_c = '0;
        end else begin
            om_res_c = {1'b0, 8'd127 - 8'(om_lz_c), 23'(om_diff_c << om_lz_c)};
        end
    end

    assign clamp_c  = act_q[31] || (act_q[30:23] == 8'd0) || (act_q[30:23] >= 8'd127);
    assign accept_c = start && ((state_q == S_IDLE) || (state_q == S_DONE));

    // Next-state and datapath sequencing
    always_comb begin
        state_d = state_q;
        act_d   = act_q;
        err_d   = err_q;
        acc_d   = acc_q;
        delta_d = delta_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: ;
            S_SUB: begin
                acc_d   = om_res_c;
                state_d = S_MUL1;
            end
            S_MUL1: begin
                acc_d   = mul_res_c;
                state_d = S_MUL2;
            end
            S_MUL2: begin
                acc_d   = mul_res_c;
`ifdef H1_DELTA_LR_EN
                state_d = S_MUL3;
`else
                state_d = S_DONE;
`endif
            end
`ifdef H1_DELTA_LR_EN
            S_MUL3: begin
                acc_d   = mul_res_c;
                state_d = S_DONE;
            end
`endif
            S_DONE: begin
                delta_d = clamp_c ? '0 : acc_q;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (accept_c) begin
            act_d   = act;
            err_d   = err;
            state_d = S_SUB;
        end
        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            act_q   <= '0;
            err_q   <= '0;
            acc_q   <= '0;
            delta_q <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            act_q   <= act_d;
            err_q   <= err_d;
            acc_q   <= acc_d;
            delta_q <= delta_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign delta = delta_q;

endmodule

// File: tb/tb_h1_delta.sv
// Bench for h1_delta: directed test-plan cases plus randomized operands checked
// against a field-level arithmetic model of delta = e * y * (1 - y) [* LR].
module tb_h1_delta;

`ifdef H1_DELTA_LR_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 4;
`endif
    localparam logic [31:0] LR = 32'h3DCCCCCD;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] act;
    logic [31:0] err;
    logic        busy;
    logic        done;
    logic [31:0] delta;

    int n_vec = 0;
    int n_err = 0;

    h1_delta #(.LR(LR)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .act   (act),
        .err   (err),
        .busy  (busy),
        .done  (done),
        .delta (delta)
    );

    always #5 clk = ~clk;

    // Reference: exact integer product, normalised by halving until it fits 24 bits
    function automatic logic [31:0] m_mul(input logic [31:0] a, input logic [31:0] b);
        logic   s;
        int     ea, eb, k, e;
        longint p;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if (ea == 0 || eb == 0) return {s, 31'd0};
        p = longint'({1'b1, a[22:0]}) * longint'({1'b1, b[22:0]});
        k = 0;
        while (p >= (64'sd1 <<< 24)) begin
            p = p >>> 1;
            k++;
        end
        e = ea + eb - 150 + k;
        if (e <= 0) return {s, 31'd0};
        if (e >= 255) return {s, 31'h7F7FFFFF};
        return {s, 8'(e), 23'(p)};
    endfunction

    // Reference: 1 - floor(y * 2^23)/2^23, then rebuilt as a float by doubling
    function automatic logic [31:0] m_om(input logic [31:0] y);
        int ey, m, sh, yfix, om, ex;
        ey   = int'(y[30:23]);
        m    = int'({1'b1, y[22:0]});
        sh   = 127 - ey;
        yfix = (sh >= 24) ? 0 : (m >> sh);
        om   = (1 << 23) - yfix;
        ex   = 127;
        while (om < (1 << 23)) begin
            om = om << 1;
            ex--;
        end
        return {1'b0, 8'(ex), 23'(om)};
    endfunction

    function automatic logic [31:0] scale(input logic [31:0] x);
`ifdef H1_DELTA_LR_EN
        return m_mul(x, LR);
`else
        return x;
`endif
    endfunction

    function automatic logic [31:0] model(input logic [31:0] y, input logic [31:0] e);
        int ey;
        ey = int'(y[30:23]);
        if (y[31] || ey == 0 || ey >= 127) return 32'h0;
        return scale(m_mul(m_mul(y, m_om(y)), e));
    endfunction

    function automatic logic [31:0] rand_act();
        case ($urandom_range(0, 7))
            0:       return {1'b1, 8'($urandom_range(100, 126)), 23'($urandom)};
            1:       return {1'b0, 8'($urandom_range(127, 140)), 23'($urandom)};
            2:       return {1'b0, 8'd0, 23'($urandom)};
            default: return {1'b0, 8'($urandom_range(90, 126)), 23'($urandom)};
        endcase
    endfunction

    function automatic logic [31:0] rand_err();
        if ($urandom_range(0, 5) == 0) return {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
        return {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One request from IDLE; checks busy/done every cycle and delta at completion
    task automatic run_op(input logic [31:0] a, input logic [31:0] e, input logic [31:0] exp, input string tag);
        start = 1'b1;
        act   = a;
        err   = e;
        tick();
        start = 1'b0;
        act   = $urandom;
        err   = $urandom;
        for (int i = 0; i < LAT - 1; i++) begin
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            chk({tag, "_early_done"}, 32'(done), 32'd0);
            tick();
        end
        chk({tag, "_done_state_busy"}, 32'(busy), 32'd0);
        chk({tag, "_early_done"}, 32'(done), 32'd0);
        tick();
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_delta"}, delta, exp);
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    // Start held high across two operations; second accepted in the DONE cycle
    task automatic run_b2b(input logic [31:0] a1, input logic [31:0] e1,
                           input logic [31:0] a2, input logic [31:0] e2);
        start = 1'b1;
        act   = a1;
        err   = e1;
        tick();
        act = a2;
        err = e2;
        for (int i = 0; i < LAT - 1; i++) begin
            chk("b2b_busy1", 32'(busy), 32'd1);
            tick();
        end
        chk("b2b_done_state", 32'(busy), 32'd0);
        tick();
        start = 1'b0;
        act   = $urandom;
        err   = $urandom;
        chk("b2b_done1", 32'(done), 32'd1);
        chk("b2b_delta1", delta, model(a1, e1));
        chk("b2b_busy2", 32'(busy), 32'd1);
        tick();
        for (int i = 0; i < LAT - 1; i++) begin
            chk("b2b_gap_done", 32'(done), 32'd0);
            tick();
        end
        chk("b2b_done2", 32'(done), 32'd1);
        chk("b2b_delta2", delta, model(a2, e2));
    endtask

    initial begin
        logic [31:0] a, e;
        rst   = 1'b1;
        start = 1'b0;
        act   = '0;
        err   = '0;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_delta", delta, 32'h0);
        rst = 1'b0;
        tick();

        run_op(32'h3F000000, 32'h3F800000, scale(32'h3E800000), "half_one");
        run_op(32'h3F400000, 32'h40800000, scale(32'h3F400000), "q3_four");
        run_op(32'h3F400000, 32'hC0000000, scale(32'hBEC00000), "q3_neg2");
`ifdef H1_DELTA_LR_EN
        run_op(32'h3F000000, 32'h3F800000, 32'h3CCCCCCD, "lr_half_one");
`endif
        run_op(32'h3F800000, 32'h3F800000, 32'h0, "clamp_one");
        run_op(32'h3F400000, 32'h40800000, scale(32'h3F400000), "reload");
        run_op(32'hBF000000, 32'h3F800000, 32'h0, "clamp_neg");
        run_op(32'h3F400000, 32'h40800000, scale(32'h3F400000), "reload2");
        run_op(32'h00000000, 32'h3F800000, 32'h0, "clamp_zero");

        run_b2b(32'h3F000000, 32'h3F800000, 32'h3F400000, 32'hC0000000);

        // Reset while in MUL1 discards the computation
        start = 1'b1;
        act   = 32'h3F400000;
        err   = 32'h40800000;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_delta", delta, 32'h0);
        chk("midrst_busy", 32'(busy), 32'd0);
        for (int i = 0; i < LAT + 1; i++) begin
            tick();
            chk("midrst_no_done", 32'(done), 32'd0);
        end
        run_op(32'h3F000000, 32'h3F800000, scale(32'h3E800000), "after_rst");

        // Reset and start on the same edge: request dropped
        rst   = 1'b1;
        start = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        chk("rst_start_busy", 32'(busy), 32'd0);
        for (int i = 0; i < LAT + 1; i++) begin
            tick();
            chk("rst_start_no_done", 32'(done), 32'd0);
        end

        for (int n = 0; n < 40; n++) begin
            a = rand_act();
            e = rand_err();
            run_op(a, e, model(a, e), "rand");
        end
        for (int n = 0; n < 8; n++) begin
            run_b2b(rand_act(), rand_err(), rand_act(), rand_err());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
